ram_arbiter: RTL and testbench



---
 rtl/mlp_mem_pkg.sv | 18 +
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/rr_pick2.sv | 22 ++
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_mem_pkg.sv
// Types and constants shared by the RAM and its arbiter. Defines the arbiter
// sequencer states, the port numbering and the default bus widths.
package mlp_mem_pkg;

  localparam int ADDR_BITS = 4;
  localparam int DATA_BITS = 8;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } ram_arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/response bundle between the two memory masters and ram_arbiter.
// Port 0 is instruction fetch and port 1 is load/store.
interface ram_arbiter_if #(
  parameter int ADDR_BITS = mlp_mem_pkg::ADDR_BITS,
  parameter int DATA_BITS = mlp_mem_pkg::DATA_BITS
);

  logic                 p0_req;
  logic                 p0_we;
  logic [ADDR_BITS-1:0] p0_addr;
  logic [DATA_BITS-1:0] p0_wdata;
  logic [DATA_BITS-1:0] p0_rdata;
  logic                 p0_ack;

  logic                 p1_req;
  logic                 p1_we;
  logic [ADDR_BITS-1:0] p1_addr;
  logic [DATA_BITS-1:0] p1_wdata;
  logic [DATA_BITS-1:0] p1_rdata;
  logic                 p1_ack;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_rdata, p0_ack, p1_rdata, p1_ack
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_rdata, p0_ack, p1_rdata, p1_ack
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the port that was not
// granted last wins; a lone requester always wins.
module rr_pick2
  import mlp_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = PORT_FETCH;
    if (req_i == 2'b11) begin
      idx_o = ~last_i;
    end else if (req_i[1]) begin
      idx_o = PORT_LSU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and setup/strobe/hold sequencer for the
// single-port RAM. Each access takes four cycles including the ack cycle.
module ram_arbiter #(
  parameter int ADDR_BITS = mlp_mem_pkg::ADDR_BITS,
  parameter int DATA_BITS = mlp_mem_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_arbiter_if.slave         bus,
  output logic [ADDR_BITS-1:0] ram_address,
  inout  wire  [DATA_BITS-1:0] ram_data,
  output logic                 ram_out_en,
  output logic                 ram_write_en
);

  import mlp_mem_pkg::*;

  ram_arb_state_t       state_q, state_d;
  logic                 last_q, last_d;
  logic                 gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata0_q, rdata0_d;
  logic [DATA_BITS-1:0] rdata1_q, rdata1_d;

  logic pick_valid;
  logic pick_idx;

  rr_pick2 u_pick (
    .req_i   ({bus.p1_req, bus.p0_req}),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // last_q resets to the LSU port so that the first tie goes to fetch.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= PORT_LSU;
      gnt_q    <= PORT_FETCH;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          last_d  = pick_idx;
          we_d    = pick_idx ? bus.p1_we    : bus.p0_we;
          addr_d  = pick_idx ? bus.p1_addr  : bus.p0_addr;
          wdata_d = pick_idx ? bus.p1_wdata : bus.p0_wdata;
          state_d = SETUP;
        end
      end
      SETUP: state_d = STROBE;
      STROBE: begin
        // Read data has had a full cycle of out_en to settle by this edge.
        if (!we_q) begin
          if (gnt_q == PORT_FETCH) rdata0_d = ram_data;
          else                     rdata1_d = ram_data;
        end
        state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_address  = addr_q;
  assign ram_write_en = (state_q == STROBE) && we_q;
  assign ram_out_en   = ((state_q == SETUP) || (state_q == STROBE)) && !we_q;

  // Driven only for a latched write, so never while out_en is high.
  assign ram_data = (we_q && (state_q != IDLE)) ? wdata_q : 'z;

  assign bus.p0_ack   = (state_q == HOLD) && (gnt_q == PORT_FETCH);
  assign bus.p1_ack   = (state_q == HOLD) && (gnt_q == PORT_LSU);
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: drivers queue expected accesses per port,
// a monitor checks every ack against a memory/arbitration reference model.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ram_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

  logic [AW-1:0] ram_address;
  tri   [DW-1:0] ram_data;
  logic          ram_out_en;
  logic          ram_write_en;

  ram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_out_en   (ram_out_en),
    .ram_write_en (ram_write_en)
  );

  always #5 clk = ~clk;

  // Simple RAM on the far side of the bus.
  logic [DW-1:0] mem_ram [16];
  logic          ram_ready = 1'b0;
  assign ram_data = ram_out_en ? mem_ram[ram_address] : 'z;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16; i++) mem_ram[i] <= 8'(i * 37 + 11);
      ram_ready <= 1'b1;
    end else if (ram_write_en) begin
      mem_ram[ram_address] <= ram_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state.
  txn_t          sb0[$];
  txn_t          sb1[$];
  logic [DW-1:0] model_mem [16];
  bit            model_def [16];
  logic [DW-1:0] rdm [2];
  bit            last_model;
  int            last_ack_cyc;
  int            ack_log[$];

  // Per-cycle history of bus activity, indexed by cycle number mod 8.
  bit            we_h [8];
  bit            oe_h [8];
  logic [AW-1:0] ad_h [8];
  logic [DW-1:0] da_h [8];
  logic [1:0]    req_h [8];
  int            cyc = 0;

  task automatic handle_ack(input int p, input int k);
    logic [1:0]    rq;
    int            exp_p;
    txn_t          t;
    logic [DW-1:0] own, other;
    logic [3:0]    wev, oev;
    int            pending;
    rq    = req_h[(k - 3) & 7];
    exp_p = (rq == 2'b11) ? int'(!last_model) : (rq[1] ? 1 : (rq[0] ? 0 : -1));
    check("grant_port", p, exp_p);
    check("ack_spacing", 32'((k - last_ack_cyc) >= 4), 1);
    last_ack_cyc = k;
    last_model   = p[0];
    ack_log.push_back(p);

    pending = (p == 0) ? sb0.size() : sb1.size();
    check("sb_pending", 32'(pending > 0), 1);
    if (pending == 0) return;
    t = (p == 0) ? sb0.pop_front() : sb1.pop_front();

    own   = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
    other = (p == 0) ? bus.p1_rdata : bus.p0_rdata;
    wev   = {we_h[(k-3)&7], we_h[(k-2)&7], we_h[(k-1)&7], we_h[k&7]};
    oev   = {oe_h[(k-3)&7], oe_h[(k-2)&7], oe_h[(k-1)&7], oe_h[k&7]};

    if (t.we) begin
      check("wr_we_seq", wev, 4'b0010);
      check("wr_oe_seq", oev, 4'b0000);
      check("wr_addr_stable", {ad_h[(k-2)&7], ad_h[(k-1)&7], ad_h[k&7]}, {t.addr, t.addr, t.addr});
      check("wr_data_stable", {da_h[(k-2)&7], da_h[(k-1)&7], da_h[k&7]}, {t.wdata, t.wdata, t.wdata});
      check("wr_rdata_kept", own, rdm[p]);
      model_mem[t.addr] = t.wdata;
      model_def[t.addr] = 1'b1;
    end else begin
      check("rd_we_seq", wev, 4'b0000);
      check("rd_oe_seq", oev, 4'b0110);
      check("rd_addr_stable", {ad_h[(k-2)&7], ad_h[(k-1)&7]}, {t.addr, t.addr});
      if (model_def[t.addr]) begin
        check("rd_data", own, model_mem[t.addr]);
        rdm[p] = model_mem[t.addr];
      end else begin
        rdm[p] = own;
      end
    end
    check("other_rdata_kept", other, rdm[1-p]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'(i * 37 + 11);
      model_def[i] = 1'b1;
    end
    rdm[0] = '0;
    rdm[1] = '0;
    last_model   = 1'b1;
    last_ack_cyc = -100;
    forever begin
      @(posedge clk);
      req_h[cyc & 7] = {bus.p1_req, bus.p0_req};
      if (reset) begin
        last_model   = 1'b1;
        rdm[0]       = '0;
        rdm[1]       = '0;
        last_ack_cyc = -100;
      end
      cyc++;
      @(negedge clk);
      we_h[cyc & 7] = ram_write_en;
      oe_h[cyc & 7] = ram_out_en;
      ad_h[cyc & 7] = ram_address;
      da_h[cyc & 7] = ram_data;
      check("no_contention", ram_write_en & ram_out_en, 0);
      check("single_ack", bus.p0_ack & bus.p1_ack, 0);
      if (bus.p0_ack) handle_ack(0, cyc);
      if (bus.p1_ack) handle_ack(1, cyc);
    end
  end

  task automatic set_req(input int p, input logic v);
    if (p == 0) bus.p0_req = v;
    else        bus.p1_req = v;
  endtask

  // Called at negedge+1; returns at negedge+1 of the ack cycle with req low.
  task automatic access(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap);
    txn_t t;
    int   n;
    bit   got;
    if (gap > 0) begin
      set_req(p, 1'b0);
      repeat (gap) begin
        @(negedge clk);
        #1;
      end
    end
    t.we = we; t.addr = a; t.wdata = d;
    if (p == 0) begin
      bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_req = 1'b1;
      sb0.push_back(t);
    end else begin
      bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_req = 1'b1;
      sb1.push_back(t);
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = (p == 0) ? bus.p0_ack : bus.p1_ack;
    end
    check("ack_timeout", got, 1);
    #1;
    set_req(p, 1'b0);
  endtask

  function automatic logic [3:0] pack_log();
    logic [3:0] v = '1;
    for (int i = 0; i < 4 && i < ack_log.size(); i++) v[3-i] = ack_log[i][0];
    return v;
  endfunction

  initial begin
    int n;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    reset = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_p0_ack", bus.p0_ack, 0);
    check("rst_p1_ack", bus.p1_ack, 0);
    check("rst_write_en", ram_write_en, 0);
    check("rst_out_en", ram_out_en, 0);
    check("rst_address", ram_address, 0);
    check("rst_p0_rdata", bus.p0_rdata, 0);
    check("rst_p1_rdata", bus.p1_rdata, 0);
    #1 reset = 1'b0;

    // Port 0 write, then port 1 reads it back.
    access(0, 1'b1, 4'd3, 8'hA5, 1);
    access(1, 1'b0, 4'd3, 8'h00, 1);
    check("p1_rdata_a5", bus.p1_rdata, 8'hA5);
    check("p0_rdata_untouched", bus.p0_rdata, 8'h00);

    // Continuous requests from both ports straight after reset.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    ack_log.delete();
    fork
      begin
        access(0, 1'b1, 4'd1, 8'h11, 0);
        access(0, 1'b1, 4'd1, 8'h12, 0);
      end
      begin
        access(1, 1'b1, 4'd2, 8'h21, 0);
        access(1, 1'b1, 4'd2, 8'h22, 0);
      end
    join
    check("alt_count", ack_log.size(), 4);
    check("alt_order", pack_log(), 4'b0101);

    // Reset while the write strobe is high.
    bus.p0_we = 1'b1; bus.p0_addr = 4'd5; bus.p0_wdata = 8'h3C; bus.p0_req = 1'b1;
    n = 0;
    while (!ram_write_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("saw_write_en", ram_write_en, 1);
    #1;
    reset = 1'b1;
    bus.p0_req = 1'b0;
    model_def[5] = 1'b0;
    @(negedge clk);
    check("abort_write_en", ram_write_en, 0);
    check("abort_out_en", ram_out_en, 0);
    check("abort_p0_ack", bus.p0_ack, 0);
    check("abort_p1_ack", bus.p1_ack, 0);
    check("abort_address", ram_address, 0);
    check("abort_p0_rdata", bus.p0_rdata, 0);
    check("abort_p1_rdata", bus.p1_rdata, 0);
    #1 reset = 1'b0;
    access(0, 1'b1, 4'd5, 8'h3C, 1);
    access(1, 1'b0, 4'd5, 8'h00, 1);
    check("reissued_write", bus.p1_rdata, 8'h3C);

    // Port 0 streams three reads; port 1 arrives during the first one.
    ack_log.delete();
    fork
      begin
        access(0, 1'b0, 4'd3, 8'h00, 1);
        access(0, 1'b0, 4'd5, 8'h00, 0);
        access(0, 1'b0, 4'd1, 8'h00, 0);
      end
      access(1, 1'b0, 4'd2, 8'h00, 3);
    join
    check("fair_count", ack_log.size(), 4);
    check("fair_order", pack_log(), 4'b0100);

    // Random mixed traffic from both ports.
    fork
      for (int i = 0; i < 40; i++)
        access(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               8'($urandom), int'($urandom_range(0, 3)));
      for (int j = 0; j < 40; j++)
        access(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               8'($urandom), int'($urandom_range(0, 3)));
    join

    repeat (4) @(negedge clk);
    check("sb_drained", sb0.size() + sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
